// File: rtl/apb_psram_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_psram_bridge_pkg
// Description : Shared types and constants for the APB-to-Wishbone PSRAM
//               bridge: FSM state encoding, legal write-strobe patterns,
//               address-match field width and timeout counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_psram_bridge_pkg;

    // Bridge FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_e;

    // Number of upper address bits compared against the base address
    localparam int unsigned c_ADDR_MATCH_W = 8;

    // Width of the Wishbone wait counter
    localparam int unsigned c_TMR_W = 16;

    // Byte-lane patterns the PSRAM controller accepts on writes
    // (single byte, aligned half-word, full word)
    localparam int unsigned c_NUM_LEGAL_STRB = 7;
    localparam logic [c_NUM_LEGAL_STRB*4-1:0] c_LEGAL_STRB = {
        4'b0001, 4'b0010, 4'b0100, 4'b1000,
        4'b0011, 4'b1100, 4'b1111
    };

    // True when the strobe matches one of the accepted patterns
    function automatic logic strb_is_legal(input logic [3:0] strb);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < c_NUM_LEGAL_STRB; i++) begin
            if (c_LEGAL_STRB[i*4 +: 4] == strb) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_psram_bridge_tmr.sv
`default_nettype none
// ============================================================================
// Module      : apb_psram_bridge_tmr
// Description : Loadable wait counter. Cleared by load_i, counts while en_i
//               is high and flags expiry on the LIMIT-th enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_psram_bridge_tmr
    import apb_psram_bridge_pkg::*;
#(
    parameter int unsigned LIMIT = 1023
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    // Count value reached during the LIMIT-th enabled cycle
    localparam int unsigned        c_LAST_I = LIMIT - 1;
    localparam logic [c_TMR_W-1:0] c_LAST   = c_LAST_I[c_TMR_W-1:0];

    logic [c_TMR_W-1:0] cnt_q;
    logic [c_TMR_W-1:0] cnt_d;
    logic               w_at_last;

    assign w_at_last = (cnt_q == c_LAST);
    assign expire_o  = en_i & w_at_last;

    // Next count: clear on load, otherwise advance and saturate at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !w_at_last) begin
            cnt_d = cnt_q + {{(c_TMR_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_psram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_psram_bridge
// Description : APB slave to Wishbone master bridge in front of a PSRAM
//               controller. Captures the request in the APB setup phase,
//               rejects off-window addresses and unsupported byte strobes,
//               runs one Wishbone cycle with a bounded wait and returns the
//               result by extending the APB access phase.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_psram_bridge
    import apb_psram_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // APB slave
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic        pready,
    output logic        pslverr,
    output logic [31:0] prdata,
    // Wishbone master
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i
);

    localparam int unsigned c_OFS_W = 32 - c_ADDR_MATCH_W;

    state_e      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic [31:0] prdata_q, prdata_d;
    logic        err_q, err_d;

    logic w_setup;
    logic w_access;
    logic w_addr_hit;
    logic w_strb_zero;
    logic w_strb_bad;
    logic w_illegal;
    logic w_in_bus;
    logic w_tmr_expire;

    assign w_setup     = psel & ~penable;
    assign w_access    = psel & penable;
    assign w_addr_hit  = (paddr[31 -: c_ADDR_MATCH_W] == BASE_ADDR[31 -: c_ADDR_MATCH_W]);
    assign w_strb_zero = pwrite & (pstrb == 4'b0000);
    assign w_strb_bad  = pwrite & ~w_strb_zero & ~strb_is_legal(pstrb);
    // An address miss takes priority, so a zero-strobe write off-window errors
    assign w_illegal   = ~w_addr_hit | w_strb_bad;
    assign w_in_bus    = (state_q == BUS);

    // Wishbone wait counter: held clear outside BUS, counts inside it
    apb_psram_bridge_tmr #(
        .LIMIT    (TIMEOUT_CYC)
    ) u_tmr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (~w_in_bus),
        .en_i     (w_in_bus),
        .expire_o (w_tmr_expire)
    );

    // Wishbone outputs come straight from the request registers
    assign cyc_o  = w_in_bus;
    assign stb_o  = w_in_bus;
    assign adr_o  = adr_q;
    assign dat_o  = dat_q;
    assign sel_o  = sel_q;
    assign we_o   = we_q;
    assign prdata = prdata_q;

    // FSM next state and APB response; responses only complete in an access phase
    always_comb begin
        state_d = state_q;
        pready  = 1'b0;
        pslverr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (w_setup) begin
                    if (w_illegal) begin
                        state_d = ERR;
                    end else if (w_strb_zero) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                // ack takes precedence over a coincident timeout
                if (ack_i || w_tmr_expire) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (w_access) begin
                    pready  = 1'b1;
                    pslverr = err_q;
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (w_access) begin
                    pready  = 1'b1;
                    pslverr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture, read data capture and timeout error tracking
    always_comb begin
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        prdata_d = prdata_q;
        err_d    = err_q;
        if (state_q == IDLE && w_setup) begin
            adr_d = {{c_ADDR_MATCH_W{1'b0}}, paddr[c_OFS_W-1:0]};
            dat_d = pwdata;
            sel_d = pwrite ? pstrb : 4'hF;
            we_d  = pwrite;
            err_d = 1'b0;
            if (w_illegal) begin
                prdata_d = 32'h0;
            end
        end
        if (w_in_bus) begin
            if (ack_i) begin
                if (!we_q) begin
                    prdata_d = dat_i;
                end
            end else if (w_tmr_expire) begin
                err_d    = 1'b1;
                prdata_d = 32'h0;
            end
        end
        if (state_q == RESP && w_access) begin
            err_d = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            adr_q    <= 32'h0;
            dat_q    <= 32'h0;
            sel_q    <= 4'h0;
            we_q     <= 1'b0;
            prdata_q <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            prdata_q <= prdata_d;
            err_q    <= err_d;
        end
    end

endmodule
`default_nettype wire
